// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parameterised register file with a power-up clearing sweep
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 2**ADDR_W - 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              RegWre,
  input  logic [1:0]        RegDst,
  input  logic              WrRegDSrc,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] drDB,
  input  logic [DATA_W-1:0] PC_add_4,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  output logic [DATA_W-1:0] writeData,
  output logic              ready
);

  localparam int                DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic                ready_q;
  logic [DATA_W-1:0]   regs_q [DEPTH];

  logic [ADDR_W-1:0]   waddr;
  logic                wr_en;

  always_comb begin
    writeData = WrRegDSrc ? drDB : PC_add_4;
  end

  always_comb begin
    waddr = '0;
    case (RegDst)
      2'b01:   waddr = rt;
      2'b10:   waddr = rd;
      2'b00:   waddr = LINK_ADDR;
      default: waddr = '0;
    endcase
  end

  // Address 0 is hard-wired to zero, so a write aimed there is simply dropped.
  always_comb begin
    wr_en = (state_q == RUN) && RegWre && (RegDst != 2'b11) && (waddr != '0);
  end

  always_comb begin
    Data1 = '0;
    Data2 = '0;
    if (state_q == RUN) begin
      if (rs != '0) Data1 = regs_q[rs];
      if (rt != '0) Data2 = regs_q[rt];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (waddr == rs)) Data1 = writeData;
      if (wr_en && (waddr == rt)) Data2 = writeData;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          regs_q[ptr_q] <= '0;
          ptr_q         <= ptr_q + ADDR_W'(1);
          if (ptr_q == LAST_ADDR) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (wr_en) regs_q[waddr] <= writeData;
        end
        default: begin
          state_q <= INIT;
          ptr_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - self-checking bench for reg_file_param
module tb_reg_file_param;

  logic        CLK = 1'b0;
  logic        Reset, RegWre, WrRegDSrc;
  logic [1:0]  RegDst;
  logic [4:0]  rs, rt, rd;
  logic [31:0] drDB, PC_add_4;
  logic [31:0] Data1, Data2, writeData;
  logic        ready;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] mdl [32];
  int          mdl_init_left;

  reg_file_param dut (
    .CLK(CLK), .Reset(Reset), .RegWre(RegWre), .RegDst(RegDst),
    .WrRegDSrc(WrRegDSrc), .rs(rs), .rt(rt), .rd(rd), .drDB(drDB),
    .PC_add_4(PC_add_4), .Data1(Data1), .Data2(Data2),
    .writeData(writeData), .ready(ready)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] m_wd();
    return WrRegDSrc ? drDB : PC_add_4;
  endfunction

  function automatic logic [4:0] m_dest();
    if (RegDst == 2'd1) return rt;
    if (RegDst == 2'd2) return rd;
    return 5'd31;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (mdl_init_left > 0 || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (RegWre && RegDst != 2'd3 && m_dest() != 5'd0 && m_dest() == a) return m_wd();
`endif
    return mdl[a];
  endfunction

  task automatic step_edge();
    if (Reset) begin
      mdl_init_left = 32;
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    end else if (mdl_init_left > 0) begin
      mdl_init_left--;
    end else if (RegWre && RegDst != 2'd3 && m_dest() != 5'd0) begin
      mdl[m_dest()] = m_wd();
    end
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  dst;
    logic        src;
    logic [4:0]  a_rt;
    logic [4:0]  a_rd;
    logic [31:0] db;
    logic [31:0] pc4;
    logic [31:0] exp_wd;
    logic [4:0]  chk;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b1, 2'd2, 1'b1, 5'd1,  5'd5,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 5'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b1, 2'd0, 1'b0, 5'd2,  5'd6,  32'h55555555, 32'h00400010, 32'h00400010, 5'd31, 32'h00400010};
    vecs[2] = '{1'b1, 2'd1, 1'b1, 5'd0,  5'd4,  32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 5'd0,  32'h0};
    vecs[3] = '{1'b1, 2'd3, 1'b1, 5'd2,  5'd7,  32'h11111111, 32'h0,        32'h11111111, 5'd7,  32'h0};
    vecs[4] = '{1'b1, 2'd1, 1'b1, 5'd12, 5'd3,  32'h0BADF00D, 32'h0,        32'h0BADF00D, 5'd12, 32'h0BADF00D};
    vecs[5] = '{1'b0, 2'd2, 1'b1, 5'd1,  5'd5,  32'h00000000, 32'h0,        32'h00000000, 5'd5,  32'hDEADBEEF};
    vecs[6] = '{1'b1, 2'd2, 1'b1, 5'd1,  5'd31, 32'h13579BDF, 32'h0,        32'h13579BDF, 5'd31, 32'h13579BDF};

    Reset = 1'b1; RegWre = 1'b1; RegDst = 2'd2; WrRegDSrc = 1'b1;
    rs = 5'd9; rt = 5'd9; rd = 5'd9; drDB = 32'hCAFEF00D; PC_add_4 = 32'h4;
    mdl_init_left = 32;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;

    // Reset edge, then the clearing sweep with writes requested throughout.
    step_edge();
    check("reset_ready", {31'd0, ready}, 32'd0);
    Reset = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      step_edge();
      check($sformatf("sweep_ready_e%0d", e), {31'd0, ready}, (e == 32) ? 32'd1 : 32'd0);
      if (e < 32) check($sformatf("sweep_data1_e%0d", e), Data1, 32'd0);
    end
    RegWre = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i); rt = 5'(31 - i);
      #1;
      check($sformatf("cleared_r%0d", i), Data1, 32'd0);
    end

    for (int v = 0; v < 7; v++) begin
      RegWre = vecs[v].we; RegDst = vecs[v].dst; WrRegDSrc = vecs[v].src;
      rt = vecs[v].a_rt; rd = vecs[v].a_rd; drDB = vecs[v].db; PC_add_4 = vecs[v].pc4;
      rs = 5'd0;
      #2;
      check($sformatf("vec%0d_writeData", v), writeData, vecs[v].exp_wd);
      step_edge();
      RegWre = 1'b0; rs = vecs[v].chk; rt = vecs[v].chk;
      #2;
      check($sformatf("vec%0d_data1", v), Data1, vecs[v].exp_rd);
      check($sformatf("vec%0d_data2", v), Data2, vecs[v].exp_rd);
    end

    // Same-cycle read of a register being written.
    RegWre = 1'b1; RegDst = 2'd2; WrRegDSrc = 1'b1; rd = 5'd3; drDB = 32'h00000033; rs = 5'd0; rt = 5'd0;
    step_edge();
    rs = 5'd3; drDB = 32'hA5A5A5A5;
    #2;
`ifdef REGFILE_BYPASS_EN
    check("bypass_before_edge", Data1, 32'hA5A5A5A5);
`else
    check("nobypass_before_edge", Data1, 32'h00000033);
`endif
    step_edge();
    RegWre = 1'b0;
    #1;
    check("bypass_after_edge", Data1, 32'hA5A5A5A5);

    // Randomised traffic with occasional resets against the model.
    for (int c = 0; c < 400; c++) begin
      Reset     = ($urandom_range(0, 99) == 0);
      RegWre    = $urandom_range(0, 1);
      RegDst    = 2'($urandom_range(0, 3));
      WrRegDSrc = $urandom_range(0, 1);
      rs        = 5'($urandom_range(0, 31));
      rt        = ($urandom_range(0, 3) == 0) ? rs : 5'($urandom_range(0, 31));
      rd        = 5'($urandom_range(0, 31));
      drDB      = $urandom;
      PC_add_4  = $urandom;
      #2;
      check("rand_writeData", writeData, m_wd());
      check("rand_data1", Data1, m_read(rs));
      check("rand_data2", Data2, m_read(rt));
      check("rand_ready", {31'd0, ready}, (mdl_init_left == 0) ? 32'd1 : 32'd0);
      step_edge();
    end
    Reset = 1'b0; RegWre = 1'b0;
    for (int e = 0; e < 40 && mdl_init_left > 0; e++) step_edge();

    // Write to r9 on the same edge as Reset: the write must be lost.
    RegWre = 1'b1; RegDst = 2'd2; WrRegDSrc = 1'b1; rd = 5'd9; drDB = 32'h12345678; Reset = 1'b1;
    step_edge();
    check("rst_write_ready", {31'd0, ready}, 32'd0);
    Reset = 1'b0;
    for (int e = 1; e <= 32; e++) step_edge();
    RegWre = 1'b0; rs = 5'd9; rt = 5'd9;
    #1;
    check("rst_write_ready_after", {31'd0, ready}, 32'd1);
    check("rst_write_r9", Data1, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
